pkt_read_ctrl: RTL and testbench

- Read-side sequencer for the received-packet store: the byte register file plus the packet-length FIFO.
- Pops one packet length per packet and generates the read addresses for that packet's bytes.
- Streams the bytes to the transmit side with dv/sop/eop framing, then enforces an inter-frame gap.
- Tracks the running base address of the circularly-written packet memory, so packets are read back in arrival order.

---
 rtl/pkt_read_ctrl.sv | 150 +++++++++++++++
 tb/tb_pkt_read_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_read_ctrl.sv
// Read-side sequencer for the received-packet store: pops one length per
// packet, issues that packet's byte addresses from a running circular base,
// frames the returned bytes with dv/sop/eop and then holds an inter-frame gap.
module pkt_read_ctrl #(
  parameter int pADDR = 14,
  parameter int pLEN  = 11,
  parameter int pIFG  = 12
) (
  input  logic             iclk,
  input  logic             i_rst,
  input  logic             i_fifo_empty,
  input  logic [pLEN-1:0]  i_fifo_len,
  output logic             o_fifo_rd,
  output logic [pADDR-1:0] o_rd_addr,
  input  logic [7:0]       i_rd_data,
  input  logic             i_tx_ready,
  output logic [7:0]       o_tx_d,
  output logic             o_tx_dv,
  output logic             o_tx_sop,
  output logic             o_tx_eop,
  output logic             o_drop,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, ARM, READ, GAP} state_e;

  // Gap counter runs 0..pIFG inclusive: cycle 0 is the eop byte itself,
  // the following pIFG cycles are the actual quiet time.
  localparam logic [7:0] GAP_END = 8'(pIFG);

  state_e           state_q, state_d;
  logic [pADDR-1:0] base_q, base_d;
  logic [pADDR-1:0] addr_q, addr_d;
  logic [pLEN-1:0]  idx_q, idx_d;
  logic [pLEN-1:0]  r_len_q, r_len_d;
  logic [7:0]       gap_q, gap_d;
  logic             fifo_rd_q, fifo_rd_d;
  logic             dv_q, dv_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             drop_q, drop_d;
  logic             last_byte;

  // r_len is never zero while in READ, so r_len-1 cannot underflow there.
  assign last_byte = (idx_q == (r_len_q - pLEN'(1)));

  // State register.
  always_ff @(posedge iclk or negedge i_rst) begin
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!i_fifo_empty) state_d = ARM;
      ARM: begin
        if (r_len_q == '0)   state_d = IDLE;
        else if (i_tx_ready) state_d = READ;
      end
      READ: if (last_byte) state_d = GAP;
      GAP:  if (gap_q == GAP_END) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values for each state.
  always_comb begin
    base_d    = base_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    r_len_d   = r_len_q;
    gap_d     = gap_q;
    fifo_rd_d = 1'b0;
    dv_d      = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    drop_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!i_fifo_empty) begin
          // Head is show-ahead: capture it now, pop strobe goes out next cycle.
          r_len_d   = i_fifo_len;
          fifo_rd_d = 1'b1;
        end
      end
      ARM: begin
        if (r_len_q == '0) begin
          drop_d = 1'b1;
        end else if (i_tx_ready) begin
          idx_d  = '0;
          addr_d = base_q;
        end
      end
      READ: begin
        // Flags lag the address by one cycle to line up with the memory data.
        dv_d  = 1'b1;
        sop_d = (idx_q == '0);
        eop_d = last_byte;
        if (last_byte) begin
          base_d = base_q + pADDR'(r_len_q);
          gap_d  = '0;
        end else begin
          idx_d  = idx_q + pLEN'(1);
          addr_d = base_q + pADDR'(idx_q) + pADDR'(1);
        end
      end
      GAP: gap_d = gap_q + 8'd1;
      default: ;
    endcase
  end

  // Datapath and output registers; reset aborts any packet in flight.
  always_ff @(posedge iclk or negedge i_rst) begin
    if (!i_rst) begin
      base_q    <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      r_len_q   <= '0;
      gap_q     <= '0;
      fifo_rd_q <= 1'b0;
      dv_q      <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      base_q    <= base_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      r_len_q   <= r_len_d;
      gap_q     <= gap_d;
      fifo_rd_q <= fifo_rd_d;
      dv_q      <= dv_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      drop_q    <= drop_d;
    end
  end

  assign o_fifo_rd = fifo_rd_q;
  assign o_rd_addr = addr_q;
  assign o_tx_d    = i_rd_data;
  assign o_tx_dv   = dv_q;
  assign o_tx_sop  = sop_q;
  assign o_tx_eop  = eop_q;
  assign o_drop    = drop_q;
  assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_pkt_read_ctrl.sv
// Bench for pkt_read_ctrl: FIFO and registered-read memory models, a byte
// scoreboard filled when lengths are pushed, a table of packet vectors and
// hand sequences for latency, spacing, wrap and reset-abort cases.
`timescale 1ns/1ps
module tb_pkt_read_ctrl;
  localparam int pADDR = 14;
  localparam int pLEN  = 11;
  localparam int pIFG  = 12;
  localparam int MEMSZ = 1 << pADDR;
  localparam int BUDGET = 5000;

  logic             iclk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_fifo_empty = 1'b1;
  logic [pLEN-1:0]  i_fifo_len = '0;
  logic [7:0]       i_rd_data = '0;
  logic             i_tx_ready = 1'b1;
  logic             o_fifo_rd, o_tx_dv, o_tx_sop, o_tx_eop, o_drop, o_busy;
  logic [pADDR-1:0] o_rd_addr;
  logic [7:0]       o_tx_d;

  pkt_read_ctrl #(.pADDR(pADDR), .pLEN(pLEN), .pIFG(pIFG)) dut (
    .iclk(iclk), .i_rst(i_rst), .i_fifo_empty(i_fifo_empty), .i_fifo_len(i_fifo_len),
    .o_fifo_rd(o_fifo_rd), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .i_tx_ready(i_tx_ready), .o_tx_d(o_tx_d), .o_tx_dv(o_tx_dv), .o_tx_sop(o_tx_sop),
    .o_tx_eop(o_tx_eop), .o_drop(o_drop), .o_busy(o_busy)
  );

  always #5 iclk = ~iclk;

  typedef struct { int addr; int data; bit sop; bit eop; } exp_t;
  typedef struct { int len; int ready_low; int exp_drop; int exp_bytes; int exp_first; } vec_t;

  exp_t            sb[$];
  logic [pLEN-1:0] fifo_q[$];
  logic [7:0]      mem [MEMSZ];
  vec_t            tbl [8];

  int n_vec = 0, n_err = 0;
  int cyc = 0, bytes_seen = 0, n_pops = 0, n_drops = 0;
  int first_addr = -1, eop_cyc = 0, base_m = 0, prev_addr = 0;
  bit eop_valid = 0, exact_gap = 0, prev_dv = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int req_min);
    n_vec++;
    if (act < req_min) begin
      n_err++;
      $display("FAIL %s: got %0d, required at least %0d (cycle %0d)", name, act, req_min, cyc);
    end
  endtask

  // One clock cycle: sample DUT on the falling edge, score bytes, model FIFO/memory.
  task automatic tick();
    exp_t e;
    @(negedge iclk);
    cyc++;
    if (o_tx_dv) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_byte: got dv=1 byte %0d from addr %0d, required no byte", o_tx_d, prev_addr);
      end else begin
        e = sb.pop_front();
        chk("rd_addr", prev_addr, e.addr);
        chk("tx_d", int'(o_tx_d), e.data);
        chk("tx_sop", int'(o_tx_sop), int'(e.sop));
        chk("tx_eop", int'(o_tx_eop), int'(e.eop));
        if (!e.sop) chk("no_bubble", int'(prev_dv), 1);
        if (e.sop && eop_valid) begin
          if (exact_gap) chk("eop_to_sop", cyc - eop_cyc, pIFG + 4);
          else           chk_ge("eop_to_sop_min", cyc - eop_cyc, pIFG + 4);
        end
        if (e.sop) first_addr = prev_addr;
        if (e.eop) begin eop_cyc = cyc; eop_valid = 1; end
        bytes_seen++;
        $display("byte addr=%0d data=%02h sop=%0b eop=%0b", prev_addr, o_tx_d, o_tx_sop, o_tx_eop);
      end
    end
    if (o_drop) n_drops++;
    if (o_fifo_rd) begin
      n_pops++;
      if (fifo_q.size() > 0) fifo_q.delete(0);
    end
    prev_dv   = o_tx_dv;
    prev_addr = int'(o_rd_addr);
    i_rd_data = mem[o_rd_addr];
    i_fifo_empty = (fifo_q.size() == 0);
    if (fifo_q.size() > 0) i_fifo_len = fifo_q[0];
    else                   i_fifo_len = '0;
  endtask

  // Queue a length in the FIFO and the bytes it must produce on the scoreboard.
  task automatic push_pkt(input int len);
    exp_t e;
    fifo_q.push_back(pLEN'(len));
    for (int i = 0; i < len; i++) begin
      e.addr = (base_m + i) % MEMSZ;
      e.data = int'(mem[e.addr]);
      e.sop  = (i == 0);
      e.eop  = (i == len - 1);
      sb.push_back(e);
    end
    base_m = (base_m + len) % MEMSZ;
    i_fifo_empty = 1'b0;
    i_fifo_len   = fifo_q[0];
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((o_busy || sb.size() != 0 || fifo_q.size() != 0) && n < BUDGET) begin
      tick();
      n++;
    end
    chk(name, int'(n < BUDGET), 1);
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    sb.delete(); fifo_q.delete();
    base_m = 0; eop_valid = 0;
    tick(); tick();
    i_rst = 1'b1;
    tick();
  endtask

  initial begin
    int pops0, drops0, b0, n;

    for (int a = 0; a < MEMSZ; a++) mem[a] = 8'((a * 37) ^ (a >> 5));
    for (int i = 0; i < 5; i++) mem[i] = 8'(8'hA0 + i);

    tbl[0] = '{len: 0,    ready_low: 0,  exp_drop: 1, exp_bytes: 0,    exp_first: 0};
    tbl[1] = '{len: 1,    ready_low: 0,  exp_drop: 0, exp_bytes: 1,    exp_first: 5};
    tbl[2] = '{len: 4,    ready_low: 10, exp_drop: 0, exp_bytes: 4,    exp_first: 6};
    tbl[3] = '{len: 7,    ready_low: 3,  exp_drop: 0, exp_bytes: 7,    exp_first: 10};
    tbl[4] = '{len: 0,    ready_low: 0,  exp_drop: 1, exp_bytes: 0,    exp_first: 0};
    tbl[5] = '{len: 2,    ready_low: 0,  exp_drop: 0, exp_bytes: 2,    exp_first: 17};
    tbl[6] = '{len: 13,   ready_low: 0,  exp_drop: 0, exp_bytes: 13,   exp_first: 19};
    tbl[7] = '{len: 2047, ready_low: 0,  exp_drop: 0, exp_bytes: 2047, exp_first: 32};

    // Reset state
    repeat (3) tick();
    chk("rst_fifo_rd", int'(o_fifo_rd), 0);
    chk("rst_rd_addr", int'(o_rd_addr), 0);
    chk("rst_tx_dv", int'(o_tx_dv), 0);
    chk("rst_sop_eop", int'({o_tx_sop, o_tx_eop}), 0);
    chk("rst_drop", int'(o_drop), 0);
    chk("rst_busy", int'(o_busy), 0);
    i_rst = 1'b1;
    tick();

    // Single packet of 5 with latency, then a 1-byte packet queued at eop
    pops0 = n_pops; b0 = bytes_seen;
    push_pkt(5);
    tick();
    chk("lat_fifo_rd", int'(o_fifo_rd), 1);
    chk("lat_busy", int'(o_busy), 1);
    tick();
    chk("lat_first_addr", int'(o_rd_addr), 0);
    chk("lat_pop_once", int'(o_fifo_rd), 0);
    chk("lat_no_dv_yet", int'(o_tx_dv), 0);
    tick();
    chk("lat_first_dv", int'(o_tx_dv), 1);
    n = 0;
    while (bytes_seen - b0 < 5 && n < 50) begin tick(); n++; end
    chk("single_bytes", bytes_seen - b0, 5);
    chk("single_pops", n_pops - pops0, 1);
    exact_gap = 1;
    push_pkt(1);
    wait_idle("single_follow_done");
    exact_gap = 0;
    chk("single_follow_addr", first_addr, 5);

    // Back-to-back 3 then 2 from a fresh base
    do_reset();
    pops0 = n_pops; b0 = bytes_seen;
    push_pkt(3);
    push_pkt(2);
    n = 0;
    while (bytes_seen - b0 < 3 && n < 50) begin tick(); n++; end
    exact_gap = 1;
    wait_idle("b2b_done");
    exact_gap = 0;
    chk("b2b_pops", n_pops - pops0, 2);
    chk("b2b_second_addr", first_addr, 3);
    chk("b2b_bytes", bytes_seen - b0, 5);

    // Table vectors: drops, single byte, start backpressure, mid-packet ready loss
    for (int v = 0; v < 8; v++) begin
      pops0 = n_pops; drops0 = n_drops; b0 = bytes_seen; first_addr = -1;
      i_tx_ready = (tbl[v].ready_low == 0);
      push_pkt(tbl[v].len);
      if (tbl[v].ready_low > 0) begin
        repeat (tbl[v].ready_low) tick();
        chk("arm_hold_busy", int'(o_busy), 1);
        chk("arm_hold_nobytes", bytes_seen - b0, 0);
        chk("arm_hold_pops", n_pops - pops0, 1);
        i_tx_ready = 1'b1;
      end
      n = 0;
      while ((o_busy || sb.size() != 0 || fifo_q.size() != 0) && n < BUDGET) begin
        tick();
        n++;
        if (bytes_seen > b0) i_tx_ready = 1'b0;
      end
      chk("vec_done", int'(n < BUDGET), 1);
      chk("vec_pops", n_pops - pops0, 1);
      chk("vec_drops", n_drops - drops0, tbl[v].exp_drop);
      chk("vec_bytes", bytes_seen - b0, tbl[v].exp_bytes);
      if (tbl[v].exp_bytes > 0) chk("vec_first_addr", first_addr, tbl[v].exp_first);
      $display("vector %0d len=%0d ready_low=%0d bytes=%0d first=%0d", v, tbl[v].len,
               tbl[v].ready_low, bytes_seen - b0, first_addr);
    end
    i_tx_ready = 1'b1;

    // Reset during byte 3 of a 10-byte packet
    b0 = bytes_seen;
    push_pkt(10);
    n = 0;
    while (bytes_seen - b0 < 3 && n < 50) begin tick(); n++; end
    #1 i_rst = 1'b0;
    #1;
    chk("abort_fifo_rd", int'(o_fifo_rd), 0);
    chk("abort_rd_addr", int'(o_rd_addr), 0);
    chk("abort_tx_dv", int'(o_tx_dv), 0);
    chk("abort_sop_eop", int'({o_tx_sop, o_tx_eop}), 0);
    chk("abort_drop_busy", int'({o_drop, o_busy}), 0);
    sb.delete(); fifo_q.delete(); base_m = 0; eop_valid = 0;
    repeat (3) tick();
    i_rst = 1'b1;
    tick();
    first_addr = -1;
    push_pkt(6);
    wait_idle("post_abort_done");
    chk("post_abort_addr", first_addr, 0);

    // Fill up to base 16382, then a 4-byte packet that wraps
    while (base_m != MEMSZ - 2) begin
      n = MEMSZ - 2 - base_m;
      push_pkt(n > 2047 ? 2047 : n);
      wait_idle("fill_done");
    end
    first_addr = -1;
    push_pkt(4);
    wait_idle("wrap_done");
    chk("wrap_first_addr", first_addr, MEMSZ - 2);
    push_pkt(1);
    wait_idle("after_wrap_done");
    chk("after_wrap_addr", first_addr, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
